// File: rtl/ram8_fifo_ctrl.sv
// rtl/ram8_fifo_ctrl.sv - 9-entry 16-bit valid/ready FIFO backed by an external RAM8
//
// Purpose: streams 16-bit words from a producer to a consumer. Eight words live in
// an external RAM8 and the ninth sits in a local head register. The RAM8 has a single
// shared address port; the controller hides this behind two independent handshakes.
//
// Ports:
//   clk          in   1   system clock, rising edge
//   reset        in   1   synchronous, active-high reset
//   push_valid   in   1   producer has a word on push_data
//   push_data    in  16   word to enqueue
//   push_ready   out  1   word accepted this cycle when push_valid is also high
//   pop_valid    out  1   pop_data holds the FIFO head
//   pop_data     out 16   FIFO head word (registered)
//   pop_ready    in   1   consumer takes the head this cycle
//   count        out  4   words held, 0..9
//   ram_in       out 16   RAM8 write data (always push_data)
//   ram_load     out  1   RAM8 write enable
//   ram_address  out  3   RAM8 address (write pointer on writes, read pointer otherwise)
//   ram_out      in  16   RAM8 combinational read data at ram_address

module ram8_fifo_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        push_valid,
  input  logic [15:0] push_data,
  output logic        push_ready,
  output logic        pop_valid,
  output logic [15:0] pop_data,
  input  logic        pop_ready,
  output logic [3:0]  count,
  output logic [15:0] ram_in,
  output logic        ram_load,
  output logic [2:0]  ram_address,
  input  logic [15:0] ram_out
);

  logic [2:0]  r_wr_ptr;
  logic [2:0]  r_rd_ptr;
  logic [3:0]  r_ram_cnt;
  logic        r_head_valid;
  logic [15:0] r_head_data;

  logic w_pop_fire;
  logic w_push_fire;
  logic w_head_free;
  logic w_refill;
  logic w_bypass;
  logic w_write;

  assign w_pop_fire  = r_head_valid & pop_ready;
  assign w_head_free = ~r_head_valid | w_pop_fire;

  // Refilling the head owns the address port, so it outranks any push.
  assign w_refill    = w_head_free & (r_ram_cnt != 4'd0);

  assign push_ready  = ~reset & ~w_refill & (r_ram_cnt != 4'd8);
  assign w_push_fire = push_valid & push_ready;

  // With RAM empty and the head slot free, the new word goes straight to the head.
  assign w_bypass    = ~w_refill & w_head_free & (r_ram_cnt == 4'd0) & w_push_fire;
  assign w_write     = ~w_refill & w_push_fire & ~w_bypass;

  assign ram_in      = push_data;
  assign ram_load    = w_write;
  assign ram_address = w_write ? r_wr_ptr : r_rd_ptr;

  assign pop_valid   = r_head_valid;
  assign pop_data    = r_head_data;
  assign count       = r_ram_cnt + {3'b000, r_head_valid};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr     <= 3'd0;
      r_rd_ptr     <= 3'd0;
      r_ram_cnt    <= 4'd0;
      r_head_valid <= 1'b0;
      r_head_data  <= 16'h0000;
    end else if (w_refill) begin
      r_head_data  <= ram_out;
      r_head_valid <= 1'b1;
      r_rd_ptr     <= r_rd_ptr + 3'd1;
      r_ram_cnt    <= r_ram_cnt - 4'd1;
    end else if (w_bypass) begin
      r_head_data  <= push_data;
      r_head_valid <= 1'b1;
    end else if (w_write) begin
      r_wr_ptr     <= r_wr_ptr + 3'd1;
      r_ram_cnt    <= r_ram_cnt + 4'd1;
    end else if (w_pop_fire) begin
      // Only reachable with RAM empty: a pop with RAM words would have refilled.
      r_head_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ram8_fifo_ctrl.sv
// tb/tb_ram8_fifo_ctrl.sv - directed and random scoreboard bench for ram8_fifo_ctrl

module tb_ram8_fifo_ctrl;

  logic        clk;
  logic        reset;
  logic        push_valid;
  logic [15:0] push_data;
  logic        push_ready;
  logic        pop_valid;
  logic [15:0] pop_data;
  logic        pop_ready;
  logic [3:0]  count;
  logic [15:0] ram_in;
  logic        ram_load;
  logic [2:0]  ram_address;
  logic [15:0] ram_out;

  logic [15:0] mem [0:7];
  logic [15:0] sb_q [$];
  int checks;
  int failures;
  int pops;

  ram8_fifo_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .push_valid  (push_valid),
    .push_data   (push_data),
    .push_ready  (push_ready),
    .pop_valid   (pop_valid),
    .pop_data    (pop_data),
    .pop_ready   (pop_ready),
    .count       (count),
    .ram_in      (ram_in),
    .ram_load    (ram_load),
    .ram_address (ram_address),
    .ram_out     (ram_out)
  );

  // RAM8 model: synchronous write, combinational read.
  always @(posedge clk) begin
    if (ram_load) mem[ram_address] <= ram_in;
  end
  assign ram_out = mem[ram_address];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs, wait to the falling edge, run generic checks and the scoreboard.
  task automatic drive(input logic pv, input logic [15:0] pd, input logic pr);
    push_valid = pv;
    push_data  = pd;
    pop_ready  = pr;
    @(negedge clk);
    if (reset) begin
      check("reset_ram_load", ram_load, 0);
      check("reset_push_ready", push_ready, 0);
    end else begin
      check("count_vs_model", count, sb_q.size());
      check("pop_valid_vs_model", pop_valid, sb_q.size() != 0);
      check("ram_in_eq_push_data", ram_in, push_data);
      check("no_load_when_full", ram_load && (count == 4'd9), 0);
      if (pop_valid) begin
        if (sb_q.size() == 0) check("head_without_model_word", 1, 0);
        else check("pop_data_order", pop_data, sb_q[0]);
        if (pop_ready && sb_q.size() != 0) begin
          void'(sb_q.pop_front());
          pops++;
        end
      end
      if (push_valid && push_ready) sb_q.push_back(push_data);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nxt;
    int cyc;
    checks = 0;
    failures = 0;
    pops = 0;
    reset = 1'b1;
    push_valid = 1'b0;
    push_data = 16'h0000;
    pop_ready = 1'b0;

    // Test 1: two reset cycles, then idle.
    drive(0, 16'h0000, 0); tick();
    drive(0, 16'h0000, 0); tick();
    reset = 1'b0;
    drive(0, 16'h0000, 0);
    check("t1_pop_valid", pop_valid, 0);
    check("t1_count", count, 0);
    check("t1_ram_load", ram_load, 0);
    check("t1_pop_data", pop_data, 16'h0000);
    tick();

    // Test 2: push into empty FIFO bypasses RAM.
    drive(1, 16'h1111, 0);
    check("t2_push_ready", push_ready, 1);
    check("t2_ram_load", ram_load, 0);
    tick();
    drive(0, 16'h0000, 0);
    check("t2_pop_valid", pop_valid, 1);
    check("t2_pop_data", pop_data, 16'h1111);
    check("t2_count", count, 1);
    check("t2_ram_load_idle", ram_load, 0);
    tick();
    drive(0, 16'h0000, 1); tick();
    // Pop request while empty is ignored.
    drive(0, 16'h0000, 1);
    check("empty_pop_valid", pop_valid, 0);
    check("empty_count", count, 0);
    tick();

    // Test 3: fill to 9 without popping.
    for (int i = 1; i <= 9; i++) begin
      drive(1, 16'(i), 0);
      check("t3_push_ready", push_ready, 1);
      check("t3_ram_load", ram_load, i >= 2);
      if (i >= 2) check("t3_ram_address", ram_address, i - 2);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      drive(1, 16'h000A, 0);
      check("t3_full_push_ready", push_ready, 0);
      check("t3_full_count", count, 9);
      check("t3_full_ram_load", ram_load, 0);
      tick();
    end

    // Test 4: drain at full rate.
    for (int k = 0; k <= 8; k++) begin
      drive(0, 16'h0000, 1);
      check("t4_pop_data", pop_data, k + 1);
      check("t4_count", count, 9 - k);
      check("t4_ram_load", ram_load, 0);
      if (k < 8) begin
        check("t4_ram_address", ram_address, k);
        check("t4_push_ready_refill", push_ready, 0);
      end else begin
        check("t4_push_ready_last", push_ready, 1);
      end
      tick();
    end
    drive(0, 16'h0000, 1);
    check("t4_empty_pop_valid", pop_valid, 0);
    check("t4_empty_count", count, 0);
    tick();

    // Test 5: random traffic over 40 words.
    nxt = 1;
    pops = 0;
    cyc = 0;
    while (pops < 40 && cyc < 2000) begin
      logic pv;
      logic pr;
      pv = (nxt <= 40) ? 1'($urandom_range(0, 1)) : 1'b0;
      pr = 1'($urandom_range(0, 1));
      drive(pv, 16'(16'h0100 + nxt), pr);
      if (push_valid && push_ready) nxt++;
      tick();
      cyc++;
    end
    check("t5_all_popped", pops, 40);
    check("t5_model_empty", sb_q.size(), 0);
    drive(0, 16'h0000, 0);
    check("t5_final_count", count, 0);
    tick();

    // Simultaneous push and pop with one word held: head replaced, count stays 1.
    drive(1, 16'h2222, 0); tick();
    drive(1, 16'h3333, 1);
    check("swap_push_ready", push_ready, 1);
    check("swap_ram_load", ram_load, 0);
    tick();
    drive(0, 16'h0000, 0);
    check("swap_count", count, 1);
    check("swap_pop_data", pop_data, 16'h3333);
    tick();
    drive(0, 16'h0000, 1); tick();

    // Test 6: reset mid-stream with 5 words held.
    for (int i = 0; i < 5; i++) begin
      drive(1, 16'(16'hA000 + i), 0);
      tick();
    end
    drive(0, 16'h0000, 0);
    check("t6_count_before", count, 5);
    tick();
    reset = 1'b1;
    drive(1, 16'h5555, 0);
    check("t6_reset_ram_load", ram_load, 0);
    tick();
    reset = 1'b0;
    sb_q.delete();
    drive(1, 16'hBEEF, 0);
    check("t6_count_after", count, 0);
    check("t6_pop_valid_after", pop_valid, 0);
    check("t6_bypass_ram_load", ram_load, 0);
    tick();
    drive(0, 16'h0000, 0);
    check("t6_head_valid", pop_valid, 1);
    check("t6_head_data", pop_data, 16'hBEEF);
    check("t6_head_count", count, 1);
    tick();
    drive(0, 16'h0000, 1); tick();
    drive(0, 16'h0000, 0);
    check("t6_no_stale_pop_valid", pop_valid, 0);
    check("t6_no_stale_count", count, 0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
